// File: rtl/galaga_inputs_pkg.sv
// Shared scan codes, key/control bundles and coin FSM states for the Galaga input block.
package galaga_inputs_pkg;

   // Arrow codes are matched on the low byte only so any extension prefix is accepted.
   localparam logic [7:0] SC_LEFT1    = 8'h6B;
   localparam logic [7:0] SC_RIGHT1   = 8'h74;
   localparam logic [8:0] SC_FIRE1_A  = 9'h029;
   localparam logic [8:0] SC_FIRE1_B  = 9'h014;
   localparam logic [8:0] SC_START1_A = 9'h005;
   localparam logic [8:0] SC_START1_B = 9'h016;
   localparam logic [8:0] SC_START2_A = 9'h006;
   localparam logic [8:0] SC_START2_B = 9'h01E;
   localparam logic [8:0] SC_COIN1    = 9'h02E;
   localparam logic [8:0] SC_COIN2    = 9'h036;
   localparam logic [8:0] SC_LEFT2    = 9'h023;
   localparam logic [8:0] SC_RIGHT2   = 9'h034;
   localparam logic [8:0] SC_FIRE2    = 9'h01C;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      GAP
   } coin_state_e;

   typedef struct packed {
      logic left1;
      logic right1;
      logic fire1;
      logic start1;
      logic start2;
      logic coin1;
      logic coin2;
      logic left2;
      logic right2;
      logic fire2;
   } keys_t;

   typedef struct packed {
      logic start1;
      logic start2;
      logic left1;
      logic right1;
      logic fire1;
      logic left2;
      logic right2;
      logic fire2;
   } ctrl_t;

   function automatic keys_t apply_key(keys_t k, logic [8:0] code, logic pressed);
      keys_t r;
      r = k;
      if (code[7:0] == SC_LEFT1) begin
         r.left1 = pressed;
      end else if (code[7:0] == SC_RIGHT1) begin
         r.right1 = pressed;
      end else begin
         case (code)
            SC_FIRE1_A, SC_FIRE1_B:   r.fire1  = pressed;
            SC_START1_A, SC_START1_B: r.start1 = pressed;
            SC_START2_A, SC_START2_B: r.start2 = pressed;
            SC_COIN1:                 r.coin1  = pressed;
            SC_COIN2:                 r.coin2  = pressed;
            SC_LEFT2:                 r.left2  = pressed;
            SC_RIGHT2:                r.right2 = pressed;
            SC_FIRE2:                 r.fire2  = pressed;
            default:                  r = k;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/galaga_inputs_coin_stretcher.sv
// Stretches a single-cycle coin request into a frame-timed coin pulse followed
// by a lockout gap; requests outside IDLE are discarded.
module coin_stretcher
   import galaga_inputs_pkg::*;
#(
   parameter int unsigned COIN_FRAMES = 4,
   parameter int unsigned COIN_GAP    = 2
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic req,
   input  logic tick,
   output logic coin
);

   localparam logic [3:0] FRAMES_INIT = 4'(COIN_FRAMES);
   localparam logic [3:0] GAP_INIT    = 4'(COIN_GAP);

   coin_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        coin_q, coin_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         // A tick coinciding with the request is deliberately not counted.
         IDLE: begin
            if (req) begin
               state_d = ACTIVE;
               cnt_d   = FRAMES_INIT;
            end
         end
         ACTIVE: begin
            if (tick) begin
               if (cnt_q <= 4'd1) begin
                  state_d = GAP;
                  cnt_d   = GAP_INIT;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (cnt_q <= 4'd1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      coin_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         coin_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coin_q  <= coin_d;
      end
   end

   assign coin = coin_q;

endmodule

// File: rtl/galaga_inputs.sv
// Merges PS/2 keyboard and two joysticks into Galaga player controls, with
// left/right cleaning and a frame-timed coin pulse.
module galaga_inputs
   import galaga_inputs_pkg::*;
#(
   parameter int unsigned COIN_FRAMES  = 4,
   parameter int unsigned COIN_GAP     = 2,
   parameter int unsigned SOCD_NEUTRAL = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        vblank,
   output logic        coin,
   output logic        start1,
   output logic        start2,
   output logic        left1,
   output logic        right1,
   output logic        fire1,
   output logic        left2,
   output logic        right2,
   output logic        fire2
);

   logic        toggle_q, toggle_d;
   logic        vblank_q, vblank_d;
   keys_t       keys_q, keys_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic        coin_req_q, coin_req_d;
   logic        coin_req_prev_q, coin_req_prev_d;
   logic [15:0] joy;
   logic        tick;
   logic        req;
   logic        l1, r1, l2, r2;
   logic        unused_joy;

   always_comb begin
      joy      = joystick_0 | joystick_1;
      toggle_d = ps2_key[10];
      keys_d   = keys_q;
      if (ps2_key[10] != toggle_q) begin
         keys_d = apply_key(keys_q, ps2_key[8:0], ps2_key[9]);
      end

      l1 = keys_q.left1  | joy[1];
      r1 = keys_q.right1 | joy[0];
      l2 = keys_q.left2  | joy[1];
      r2 = keys_q.right2 | joy[0];
      if (SOCD_NEUTRAL != 0) begin
         if (l1 && r1) begin
            l1 = 1'b0;
            r1 = 1'b0;
         end
         if (l2 && r2) begin
            l2 = 1'b0;
            r2 = 1'b0;
         end
      end

      ctrl_d.start1 = keys_q.start1 | joy[5];
      ctrl_d.start2 = keys_q.start2 | joy[6];
      ctrl_d.left1  = l1;
      ctrl_d.right1 = r1;
      ctrl_d.fire1  = keys_q.fire1 | joy[4];
      ctrl_d.left2  = l2;
      ctrl_d.right2 = r2;
      ctrl_d.fire2  = keys_q.fire2 | joy[4];

      coin_req_d      = keys_q.coin1 | keys_q.coin2 | joy[7];
      coin_req_prev_d = coin_req_q;
      req             = coin_req_q & ~coin_req_prev_q;

      vblank_d = vblank;
      tick     = vblank & ~vblank_q;
   end

   assign unused_joy = ^{joy[15:8], joy[3:2]};

   // Toggle and vblank history track their inputs during reset so release is glitch-free.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         toggle_q        <= ps2_key[10];
         vblank_q        <= vblank;
         keys_q          <= '0;
         ctrl_q          <= '0;
         coin_req_q      <= 1'b0;
         coin_req_prev_q <= 1'b0;
      end else begin
         toggle_q        <= toggle_d;
         vblank_q        <= vblank_d;
         keys_q          <= keys_d;
         ctrl_q          <= ctrl_d;
         coin_req_q      <= coin_req_d;
         coin_req_prev_q <= coin_req_prev_d;
      end
   end

   coin_stretcher #(
      .COIN_FRAMES(COIN_FRAMES),
      .COIN_GAP   (COIN_GAP)
   ) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .req    (req),
      .tick   (tick),
      .coin   (coin)
   );

   assign start1 = ctrl_q.start1;
   assign start2 = ctrl_q.start2;
   assign left1  = ctrl_q.left1;
   assign right1 = ctrl_q.right1;
   assign fire1  = ctrl_q.fire1;
   assign left2  = ctrl_q.left2;
   assign right2 = ctrl_q.right2;
   assign fire2  = ctrl_q.fire2;

endmodule

// File: tb/tb_galaga_inputs.sv
// Bench for galaga_inputs: default instance plus a SOCD-off, short-coin instance,
// both compared every cycle against a tick-counting behavioural model.
module tb_galaga_inputs;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0, joystick_1;
   logic        vblank;
   logic [8:0]  o0, o1;   // {coin,start1,start2,left1,right1,fire1,left2,right2,fire2}

   int checks = 0;
   int errors = 0;

   galaga_inputs dut (
      .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
      .joystick_0(joystick_0), .joystick_1(joystick_1), .vblank(vblank),
      .coin(o0[8]), .start1(o0[7]), .start2(o0[6]), .left1(o0[5]), .right1(o0[4]),
      .fire1(o0[3]), .left2(o0[2]), .right2(o0[1]), .fire2(o0[0])
   );

   galaga_inputs #(.COIN_FRAMES(3), .COIN_GAP(1), .SOCD_NEUTRAL(0)) dut_ns (
      .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
      .joystick_0(joystick_0), .joystick_1(joystick_1), .vblank(vblank),
      .coin(o1[8]), .start1(o1[7]), .start2(o1[6]), .left1(o1[5]), .right1(o1[4]),
      .fire1(o1[3]), .left2(o1[2]), .right2(o1[1]), .fire2(o1[0])
   );

   always #5 clk_sys = ~clk_sys;

   // ---------------- behavioural model ----------------
   int  fr_p [2] = '{4, 3};
   int  gp_p [2] = '{2, 1};
   bit  sn_p [2] = '{1'b1, 1'b0};

   bit [9:0]   mkeys;       // 0 L1,1 R1,2 F1,3 S1,4 S2,5 C1,6 C2,7 L2,8 R2,9 F2
   bit         tog_m, vb_m, creq_m, creqp_m;
   int         ticks_m [2] = '{99, 99};   // frame ticks since the last accepted coin
   logic [8:0] exp_o [2];
   bit         chk_en = 1'b0;

   function automatic int key_index(logic [8:0] c);
      if (c[7:0] == 8'h6B) return 0;
      if (c[7:0] == 8'h74) return 1;
      case (c)
         9'h029, 9'h014: return 2;
         9'h005, 9'h016: return 3;
         9'h006, 9'h01E: return 4;
         9'h02E:         return 5;
         9'h036:         return 6;
         9'h023:         return 7;
         9'h034:         return 8;
         9'h01C:         return 9;
         default:        return -1;
      endcase
   endfunction

   always @(posedge clk_sys) begin : model
      bit [15:0] j;
      bit tk, rq, idle, l1, r1, l2, r2;
      int idx;
      j = joystick_0 | joystick_1;
      if (reset) begin
         mkeys   = '0;
         tog_m   = ps2_key[10];
         vb_m    = vblank;
         creq_m  = 1'b0;
         creqp_m = 1'b0;
         for (int i = 0; i < 2; i++) begin
            ticks_m[i] = 99;
            exp_o[i]   = '0;
         end
      end else begin
         tk   = vblank && !vb_m;
         vb_m = vblank;
         rq   = creq_m && !creqp_m;
         for (int i = 0; i < 2; i++) begin
            idle = ticks_m[i] >= fr_p[i] + gp_p[i];
            if (idle && rq) ticks_m[i] = 0;
            else if (!idle && tk) ticks_m[i]++;
            l1 = mkeys[0] | j[1];
            r1 = mkeys[1] | j[0];
            l2 = mkeys[7] | j[1];
            r2 = mkeys[8] | j[0];
            if (sn_p[i] && l1 && r1) begin l1 = 0; r1 = 0; end
            if (sn_p[i] && l2 && r2) begin l2 = 0; r2 = 0; end
            exp_o[i] = {ticks_m[i] < fr_p[i], mkeys[3] | j[5], mkeys[4] | j[6],
                        l1, r1, mkeys[2] | j[4], l2, r2, mkeys[9] | j[4]};
         end
         creqp_m = creq_m;
         creq_m  = mkeys[5] | mkeys[6] | j[7];
         if (ps2_key[10] != tog_m) begin
            tog_m = ps2_key[10];
            idx   = key_index(ps2_key[8:0]);
            if (idx >= 0) mkeys[idx] = ps2_key[9];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_sys) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            logic [8:0] got;
            got = (i == 0) ? o0 : o1;
            checks++;
            if (got !== exp_o[i]) begin
               errors++;
               $display("FAIL model_cmp inst=%0d t=%0t got=%b want=%b", i, $time, got, exp_o[i]);
            end
         end
      end
   end

   // ---------------- coin pulse monitor ----------------
   bit mon_vb;
   bit mon_coin [2];
   int hi_ticks [2];
   int rises [2];

   always @(negedge clk_sys) begin
      bit tk, c;
      tk = vblank && !mon_vb;
      mon_vb = vblank;
      for (int i = 0; i < 2; i++) begin
         c = (i == 0) ? o0[8] : o1[8];
         if (tk && mon_coin[i]) hi_ticks[i]++;
         if (c && !mon_coin[i]) rises[i]++;
         mon_coin[i] = c;
      end
   end

   // ---------------- stimulus helpers ----------------
   bit vb_auto = 1'b1;
   int phase = 0;

   task automatic cycle();
      @(negedge clk_sys);
      #1;
      if (vb_auto) begin
         phase  = (phase + 1) % 8;
         vblank = (phase < 3);
      end
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic press(logic [8:0] code, logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         hi_ticks[i] = 0;
         rises[i]    = 0;
      end
   endtask

   task automatic check(string name, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   int unsigned codes [16] = '{'h06B, 'h16B, 'h074, 'h174, 'h029, 'h014, 'h005, 'h016,
                               'h006, 'h01E, 'h02E, 'h036, 'h023, 'h034, 'h01C, 'h05A};
   int jbits [6] = '{0, 1, 4, 5, 6, 7};

   initial begin
      bit seen, fell;
      int b;
      reset = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; vblank = 1'b0;
      run(3);
      chk_en = 1'b1;
      check("reset_out0", int'(o0), 0);
      check("reset_out1", int'(o1), 0);
      check("reset_model", int'(exp_o[0]), 0);
      reset = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cycle();
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) vblank = ~vblank;
         b = $urandom_range(0, 99);
         if (b < 15) press(9'(codes[$urandom_range(0, 15)]), 1'($urandom_range(0, 1)));
         else if (b < 18) ps2_key[9:0] = 10'($urandom);
         b = $urandom_range(0, 99);
         if (b < 14) begin
            int bit_i;
            bit_i = jbits[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1) joystick_0[bit_i] = ~joystick_0[bit_i];
            else joystick_1[bit_i] = ~joystick_1[bit_i];
         end else if (b < 16) begin
            joystick_1 = 16'($urandom) & 16'($urandom);
         end
      end

      // clean slate for directed cases
      reset = 1'b1; joystick_0 = '0; joystick_1 = '0;
      run(2);
      reset = 1'b0;
      run(16);

      // PS/2 arrow: two-clock latency, release, no event without toggle
      press(9'h06B, 1'b1);
      cycle(); check("ps2_lat1", int'(o0[5]), 0);
      cycle(); check("ps2_lat2", int'(o0[5]), 1);
      press(9'h06B, 1'b0);
      run(2);  check("ps2_release", int'(o0[5]), 0);
      ps2_key = {ps2_key[10], 1'b1, 9'h06B};
      run(3);  check("ps2_no_toggle", int'(o0[5]), 0);
      press(9'h16B, 1'b1);
      run(2);  check("ps2_ext_arrow", int'(o0[5]), 1);
      press(9'h16B, 1'b0);
      run(2);

      // SOCD
      joystick_1 = 16'h0003;
      run(2);
      check("socd_on",  int'({o0[5], o0[4], o0[2], o0[1]}), 0);
      check("socd_off", int'({o1[5], o1[4], o1[2], o1[1]}), 15);
      joystick_1 = '0;
      run(2);

      // coin key held for 20 frames, then release and re-press
      clear_counts();
      press(9'h02E, 1'b1);
      run(160);
      check("hold_ticks0", hi_ticks[0], 4);
      check("hold_pulses0", rises[0], 1);
      check("hold_ticks1", hi_ticks[1], 3);
      press(9'h02E, 1'b0);
      run(24);
      clear_counts();
      press(9'h02E, 1'b1);
      run(56);
      check("repress_pulses", rises[0], 1);
      check("repress_ticks", hi_ticks[0], 4);
      press(9'h02E, 1'b0);
      run(40);

      // joystick coin during GAP is dropped
      clear_counts();
      joystick_0[7] = 1'b1; cycle(); joystick_0[7] = 1'b0;
      seen = 0; fell = 0;
      for (int k = 0; k < 200 && !fell; k++) begin
         cycle();
         if (o0[8]) seen = 1;
         else if (seen) fell = 1;
      end
      check("gap_wait", int'(fell), 1);
      joystick_0[7] = 1'b1; cycle(); joystick_0[7] = 1'b0;
      run(40);
      check("gap_drop", rises[0], 1);
      clear_counts();
      joystick_0[7] = 1'b1; cycle(); joystick_0[7] = 1'b0;
      run(56);
      check("idle_pulse", rises[0], 1);
      check("idle_ticks", hi_ticks[0], 4);
      run(24);

      // reset in frame 2 of ACTIVE
      clear_counts();
      press(9'h02E, 1'b1);
      for (int k = 0; k < 200 && hi_ticks[0] < 1; k++) cycle();
      check("active_wait", hi_ticks[0], 1);
      run(2);
      check("pre_reset_coin", int'(o0[8]), 1);
      reset = 1'b1;
      cycle();
      check("reset_drop", int'(o0[8]), 0);
      reset = 1'b0;
      clear_counts();
      run(32);
      check("held_after_reset", rises[0], 0);
      press(9'h02E, 1'b0);
      run(8);
      press(9'h02E, 1'b1);
      run(56);
      check("reset_repress", rises[0], 1);
      press(9'h02E, 1'b0);
      run(80);

      // request on the same edge as a vblank rise
      vb_auto = 1'b0; vblank = 1'b0;
      run(3);
      clear_counts();
      joystick_0[7] = 1'b1;
      cycle();
      joystick_0[7] = 1'b0; vblank = 1'b1; phase = 0; vb_auto = 1'b1;
      run(80);
      check("same_tick_ticks0", hi_ticks[0], 4);
      check("same_tick_pulse0", rises[0], 1);
      check("same_tick_ticks1", hi_ticks[1], 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/galaga_inputs.md
GALAGA_INPUTS -- requirements
Module: galaga_inputs

Interface
REQ-001 SHALL have parameter COIN_FRAMES, default 4, giving the coin pulse length in frames (legal range 1..15).
REQ-002 SHALL have parameter COIN_GAP, default 2, giving the minimum coin-low frames before the next coin (legal range 1..15).
REQ-003 SHALL have parameter SOCD_NEUTRAL, default 1; when 1, left+right held together yields neither.
REQ-004 clk_sys  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ps2_key  input  11  [10] toggles per key event, [9] pressed, [8:0] scan code (bit 8 = extended).
REQ-007 joystick_0, joystick_1  input  16 each  bit0 right, bit1 left, bit4 fire, bit5 start1, bit6 start2, bit7 coin.
REQ-008 vblank  input  1  frame marker; the frame tick is its rising edge.
REQ-009 coin, start1, start2  output  1 each  registered, active-high.
REQ-010 left1, right1, fire1, left2, right2, fire2  output  1 each  registered, active-high.

Function
REQ-011 SHALL detect a key event on a clock edge where ps2_key[10] differs from the stored toggle, then update the stored toggle.
REQ-012 Key event SHALL load the pressed bit into the mapped key register.
- Mapping, with bit 8 ignored (any extension) for the arrows:
  - 0x6B left1; 0x74 right1.
  - 0x029 and 0x014 fire1.
  - 0x005 and 0x016 start1; 0x006 and 0x01E start2.
  - 0x02E coin1; 0x036 coin2.
  - 0x023 left2; 0x034 right2; 0x01C fire2.
- Unmapped codes are ignored.
REQ-013 Player-1 and player-2 direction/fire outputs SHALL each be key OR (joystick_0|joystick_1) bit.
REQ-014 start1/start2 SHALL be the key OR merged joystick bit 5/6.
REQ-015 With SOCD_NEUTRAL=1, left and right both asserted for a player SHALL drive both of that player's outputs 0.
REQ-016 Latency:
- joystick change to output: 1 clock.
- ps2_key event to output: 2 clocks.
REQ-017 coin_req = coin1 key | coin2 key | merged joystick bit 7, registered; only its rising edge is a coin request.
REQ-018 Coin FSM states and transitions:
- IDLE: coin=0; request -> ACTIVE with cnt=COIN_FRAMES.
- ACTIVE: coin=1; each frame tick decrements cnt; the tick at cnt=1 -> GAP with cnt=COIN_GAP.
- GAP: coin=0; each frame tick decrements cnt; the tick at cnt=1 -> IDLE.
REQ-019 Requests arriving in ACTIVE or GAP SHALL be dropped, not queued.
REQ-020 A held coin SHALL NOT retrigger; a release and re-press is required.
REQ-021 A request and a frame tick on the same IDLE edge SHALL enter ACTIVE with the full COIN_FRAMES; that tick is not counted.
REQ-022 coin SHALL be a registered decode of the state; it rises 1 clock after the coin_req rising edge.
REQ-023 cnt SHALL be 4 bits and SHALL never wrap below 0.

Reset
REQ-024 On reset:
- All outputs, key registers and coin_req SHALL be 0.
- The coin FSM SHALL be IDLE with cnt=0.
REQ-025 On reset, the stored toggle SHALL load ps2_key[10] and the vblank history SHALL load vblank, so no spurious event or tick occurs on release.
REQ-026 Reset asserted mid-pulse SHALL drop coin to 0 on the next clock edge.

Structure
REQ-027 Package galaga_inputs_pkg SHALL hold the scan-code constants and the coin state enum (IDLE, ACTIVE, GAP).
REQ-028 The coin FSM SHALL be a sub-module coin_stretcher (ports: clk_sys, reset, req, tick, coin), parameterised by COIN_FRAMES/COIN_GAP.
REQ-029 The top SHALL hold the PS/2 decode, joystick merge, SOCD logic and edge detectors.

Verification
REQ-030 Toggle ps2_key with {pressed=1, code=0x06B}:
- left1=1 two clocks later.
- Toggle with {0, 0x06B}: left1=0.
- Repeating ps2_key with an unchanged toggle: no change.
REQ-031 joystick_1 = 0x0003:
- left1=right1=left2=right2=0 (SOCD).
- With SOCD_NEUTRAL=0, all four are 1.
REQ-032 Coin key held for 20 frames, defaults:
- coin high for exactly 4 frame ticks, then low.
- No second pulse until release and re-press after 2 further ticks.
REQ-033 Joystick bit7 pulse during GAP: no coin pulse produced; a pulse after return to IDLE produces a 4-frame pulse.
REQ-034 Reset asserted in frame 2 of ACTIVE:
- coin=0 next clock; FSM IDLE.
- The held coin key does not produce a pulse until it is released and re-pressed.
REQ-035 Coin request on the same clock as a vblank rising edge: coin lasts the full 4 subsequent ticks.
